tx_char_scheduler: RTL and testbench

TX_CHAR_SCHEDULER -- requirements
Module: tx_char_scheduler

---
 rtl/tx_char_scheduler.sv | 133 +++++++++++++
 tb/tb_tx_char_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_char_scheduler.sv
// tx_char_scheduler: arbitrates NULL / FCT / N-Char / time-code transmission slots for the encoder.
// Rev 1.0
`default_nettype none

module tx_char_scheduler #(
  parameter int FCT_BURST_MAX = 7,
  parameter int CREDIT_W      = 6
) (
  input  logic                pclk_tx,
  input  logic                reset_tx,
  input  logic                enable_tx,
  input  logic                send_null_tx,
  input  logic                send_fct_tx,
  input  logic                send_nchar_tx,
  input  logic                tickin_tx,
  input  logic [2:0]          fct_owed,
  input  logic [CREDIT_W-1:0] fct_counter_p,
  input  logic                txwrite_tx,
  input  logic                char_done,
  output logic [2:0]          char_sel,
  output logic                char_start,
  output logic                ready_tx,
  output logic                fct_sent,
  output logic                nchar_sent,
  output logic                tick_ack,
  output logic                credit_zero
);

  localparam int BURST_W = $clog2(FCT_BURST_MAX + 1);

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_NULL = 3'd1;
  localparam logic [2:0] SEL_FCT  = 3'd2;
  localparam logic [2:0] SEL_NC   = 3'd3;
  localparam logic [2:0] SEL_TC   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_BUSY = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 tick_pend_q;
  logic [BURST_W-1:0]   burst_q;
  logic [BURST_W-1:0]   burst_d;
  logic [2:0]           grant_d;
  logic                 tc_ok, fct_ok, nc_ok, null_ok, burst_full;

  always_comb begin
    tc_ok      = tick_pend_q & send_nchar_tx;
    fct_ok     = send_fct_tx & (fct_owed != 3'd0);
    nc_ok      = send_nchar_tx & txwrite_tx & (fct_counter_p != '0);
    null_ok    = send_null_tx;
    burst_full = (burst_q == BURST_W'(FCT_BURST_MAX));

    // A full FCT burst lets one waiting N-Char jump ahead of further FCTs.
    grant_d = SEL_NONE;
    if (tc_ok)                    grant_d = SEL_TC;
    else if (nc_ok && burst_full) grant_d = SEL_NC;
    else if (fct_ok)              grant_d = SEL_FCT;
    else if (nc_ok)               grant_d = SEL_NC;
    else if (null_ok)             grant_d = SEL_NULL;

    burst_d = '0;
    if (grant_d == SEL_FCT) burst_d = burst_full ? burst_q : burst_q + BURST_W'(1);
  end

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state_q     <= S_IDLE;
      tick_pend_q <= 1'b0;
      burst_q     <= '0;
      char_sel    <= SEL_NONE;
      char_start  <= 1'b0;
      ready_tx    <= 1'b0;
      fct_sent    <= 1'b0;
      nchar_sent  <= 1'b0;
      tick_ack    <= 1'b0;
      credit_zero <= 1'b0;
    end else begin
      char_start  <= 1'b0;
      ready_tx    <= 1'b0;
      fct_sent    <= 1'b0;
      nchar_sent  <= 1'b0;
      tick_ack    <= 1'b0;
      credit_zero <= send_nchar_tx & txwrite_tx & (fct_counter_p == '0);

      if (!enable_tx) begin
        state_q     <= S_IDLE;
        tick_pend_q <= 1'b0;
        burst_q     <= '0;
        char_sel    <= SEL_NONE;
      end else begin
        // A new request in the clearing cycle wins, so that tick is not lost.
        if (tickin_tx)
          tick_pend_q <= 1'b1;
        else if (state_q == S_ACK && char_sel == SEL_TC)
          tick_pend_q <= 1'b0;

        case (state_q)
          S_IDLE: state_q <= S_ARB;
          S_ARB: begin
            if (grant_d != SEL_NONE) begin
              char_sel   <= grant_d;
              char_start <= 1'b1;
              ready_tx   <= (grant_d == SEL_NC);
              burst_q    <= burst_d;
              state_q    <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (char_done) begin
              fct_sent   <= (char_sel == SEL_FCT);
              nchar_sent <= (char_sel == SEL_NC);
              tick_ack   <= (char_sel == SEL_TC);
              state_q    <= S_ACK;
            end
          end
          S_ACK: begin
            char_sel <= SEL_NONE;
            state_q  <= S_ARB;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_char_scheduler.sv
// tb_tx_char_scheduler: directed scenarios plus randomized traffic against a reference model.
// Rev 1.0
`default_nettype none

module tb_tx_char_scheduler;

  localparam int FCT_BURST_MAX = 7;
  localparam int CREDIT_W      = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                en, send_null, send_fct, send_nchar, tickin, txwrite, char_done;
  logic [2:0]          fct_owed;
  logic [CREDIT_W-1:0] credit;
  logic [2:0]          char_sel;
  logic                char_start, ready_tx, fct_sent, nchar_sent, tick_ack, credit_zero;

  tx_char_scheduler #(.FCT_BURST_MAX(FCT_BURST_MAX), .CREDIT_W(CREDIT_W)) dut (
    .pclk_tx(clk), .reset_tx(rst), .enable_tx(en), .send_null_tx(send_null),
    .send_fct_tx(send_fct), .send_nchar_tx(send_nchar), .tickin_tx(tickin),
    .fct_owed(fct_owed), .fct_counter_p(credit), .txwrite_tx(txwrite),
    .char_done(char_done), .char_sel(char_sel), .char_start(char_start),
    .ready_tx(ready_tx), .fct_sent(fct_sent), .nchar_sent(nchar_sent),
    .tick_ack(tick_ack), .credit_zero(credit_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the character in flight, the pending tick and the
  // length of the current run of FCT grants.
  logic [2:0] e_sel = 3'd0;
  logic       e_start = 1'b0, e_ready = 1'b0, e_fs = 1'b0, e_ns = 1'b0, e_ta = 1'b0, e_cz = 1'b0;
  bit         m_armed = 1'b0, m_fin = 1'b0, m_pend = 1'b0;
  logic [2:0] m_cur = 3'd0;
  int         m_fct_run = 0;

  function automatic logic [2:0] pick();
    bit tc = m_pend && send_nchar;
    bit fc = send_fct && (fct_owed != 3'd0);
    bit nc = send_nchar && txwrite && (credit != 0);
    if (tc) return 3'd4;
    if (nc && m_fct_run >= FCT_BURST_MAX) return 3'd3;
    if (fc) return 3'd2;
    if (nc) return 3'd3;
    if (send_null) return 3'd1;
    return 3'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [2:0] g;
    bit clr;
    e_start = 1'b0; e_ready = 1'b0; e_fs = 1'b0; e_ns = 1'b0; e_ta = 1'b0;
    if (rst) begin
      e_sel = 3'd0; e_cz = 1'b0;
      m_armed = 1'b0; m_fin = 1'b0; m_pend = 1'b0; m_cur = 3'd0; m_fct_run = 0;
    end else begin
      e_cz = send_nchar && txwrite && (credit == 0);
      if (!en) begin
        m_armed = 1'b0; m_fin = 1'b0; m_pend = 1'b0; m_cur = 3'd0; m_fct_run = 0; e_sel = 3'd0;
      end else begin
        clr = m_fin && (m_cur == 3'd4);
        if (m_fin) begin
          m_fin = 1'b0; m_cur = 3'd0; e_sel = 3'd0;
        end else if (m_cur != 3'd0) begin
          if (char_done) begin
            m_fin = 1'b1;
            e_fs = (m_cur == 3'd2); e_ns = (m_cur == 3'd3); e_ta = (m_cur == 3'd4);
          end
        end else if (!m_armed) begin
          m_armed = 1'b1;
        end else begin
          g = pick();
          if (g != 3'd0) begin
            m_cur = g; e_sel = g; e_start = 1'b1; e_ready = (g == 3'd3);
            m_fct_run = (g == 3'd2) ? m_fct_run + 1 : 0;
          end
        end
        if (tickin) m_pend = 1'b1;
        else if (clr) m_pend = 1'b0;
      end
    end
  end

  // Bench-side host/encoder behaviour and tallies.
  bit         auto_done = 1'b0, drop_write = 1'b0, track_owed = 1'b0;
  int         done_cnt = 0;
  int         n_fs = 0, n_ns = 0, n_ta = 0, n_rdy = 0;
  logic [2:0] glog[$];

  task automatic check_all();
    chk("char_sel",    32'(char_sel),    32'(e_sel));
    chk("char_start",  32'(char_start),  32'(e_start));
    chk("ready_tx",    32'(ready_tx),    32'(e_ready));
    chk("fct_sent",    32'(fct_sent),    32'(e_fs));
    chk("nchar_sent",  32'(nchar_sent),  32'(e_ns));
    chk("tick_ack",    32'(tick_ack),    32'(e_ta));
    chk("credit_zero", 32'(credit_zero), 32'(e_cz));
  endtask

  task automatic clear_tally();
    n_fs = 0; n_ns = 0; n_ta = 0; n_rdy = 0; glog.delete();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
      if (char_start) begin
        glog.push_back(char_sel);
        done_cnt = 2;
      end else if (done_cnt > 0) begin
        done_cnt--;
      end
      if (auto_done) char_done = (done_cnt == 1);
      if (fct_sent)   n_fs++;
      if (nchar_sent) n_ns++;
      if (tick_ack)   n_ta++;
      if (ready_tx) begin
        n_rdy++;
        if (drop_write) txwrite = 1'b0;
      end
      if (fct_sent && track_owed && fct_owed != 3'd0) fct_owed = fct_owed - 3'd1;
    end
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (k < 50) begin
      cyc(1);
      if (char_start) break;
      k++;
    end
    chk({tag, "_start_seen"}, 32'(char_start), 32'd1);
  endtask

  task automatic go_idle();
    en = 1'b0;
    cyc(2);
    clear_tally();
  endtask

  initial begin
    int base, bad;
    rst = 1'b0; en = 1'b0; send_null = 1'b0; send_fct = 1'b0; send_nchar = 1'b0;
    tickin = 1'b0; txwrite = 1'b0; char_done = 1'b0; fct_owed = 3'd0; credit = '0;
    #1 rst = 1'b1;
    cyc(2);
    chk("reset_sel",   32'(char_sel), 32'd0);
    chk("reset_pulse", 32'({char_start, ready_tx, fct_sent, nchar_sent, tick_ack, credit_zero}), 32'd0);
    rst = 1'b0;

    // NULLs only
    auto_done = 1'b1; send_null = 1'b1; en = 1'b1;
    cyc(30);
    bad = 0;
    foreach (glog[i]) if (glog[i] != 3'd1) bad++;
    chk("null_only_nonnull", 32'(bad), 32'd0);
    chk("null_only_count", 32'(glog.size() >= 5), 32'd1);
    chk("null_only_acks", 32'(n_fs + n_ns + n_ta), 32'd0);

    // Three owed FCTs, then the waiting N-Char
    go_idle();
    send_fct = 1'b1; send_nchar = 1'b1; txwrite = 1'b1; credit = 6'd8; fct_owed = 3'd3;
    track_owed = 1'b1; drop_write = 1'b1; en = 1'b1;
    cyc(40);
    chk("fct3_len", 32'(glog.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("fct3_order", 32'(glog[i]), (i == 3) ? 32'd3 : 32'd2);
    chk("fct3_fct_sent", 32'(n_fs), 32'd3);
    chk("fct3_nchar_sent", 32'(n_ns), 32'd1);
    chk("fct3_ready", 32'(n_rdy), 32'd1);

    // Time-code request during an FCT, second request while still pending
    go_idle();
    auto_done = 1'b0; char_done = 1'b0; txwrite = 1'b0; fct_owed = 3'd2; en = 1'b1;
    wait_start("tc");
    tickin = 1'b1; cyc(1);
    tickin = 1'b0; cyc(1);
    tickin = 1'b1; cyc(1);
    tickin = 1'b0; char_done = 1'b1; cyc(1);
    char_done = 1'b0; auto_done = 1'b1;
    cyc(30);
    chk("tc_len", 32'(glog.size() >= 3), 32'd1);
    chk("tc_first_fct", 32'(glog[0]), 32'd2);
    chk("tc_next_tc", 32'(glog[1]), 32'd4);
    chk("tc_then_fct", 32'(glog[2]), 32'd2);
    chk("tc_ack_count", 32'(n_ta), 32'd1);

    // Sustained owed FCTs with a waiting N-Char: burst limit
    go_idle();
    track_owed = 1'b0; drop_write = 1'b0; send_null = 1'b0;
    fct_owed = 3'd7; txwrite = 1'b1; credit = 6'd8; en = 1'b1;
    cyc(60);
    chk("burst_len", 32'(glog.size() >= 9), 32'd1);
    for (int i = 0; i < 9; i++) chk("burst_order", 32'(glog[i]), (i == 7) ? 32'd3 : 32'd2);

    // Zero credit blocks N-Chars until credit arrives
    go_idle();
    send_fct = 1'b0; fct_owed = 3'd0; credit = '0; txwrite = 1'b1; send_null = 1'b1;
    drop_write = 1'b1; en = 1'b1;
    cyc(20);
    bad = 0;
    foreach (glog[i]) if (glog[i] != 3'd1) bad++;
    chk("nocredit_nonnull", 32'(bad), 32'd0);
    chk("nocredit_ready", 32'(n_rdy), 32'd0);
    chk("nocredit_flag", 32'(credit_zero), 32'd1);
    base = glog.size();
    credit = 6'd8;
    cyc(12);
    chk("credit_nc_granted", 32'(glog[base]), 32'd3);
    chk("credit_ready", 32'(n_rdy), 32'd1);

    // Disable mid-character, then reset mid-character
    go_idle();
    auto_done = 1'b0; char_done = 1'b0; send_null = 1'b0; drop_write = 1'b0;
    txwrite = 1'b1; credit = 6'd8; en = 1'b1;
    wait_start("dis");
    chk("dis_sel", 32'(char_sel), 32'd3);
    cyc(1);
    en = 1'b0; cyc(1);
    char_done = 1'b1; cyc(2);
    char_done = 1'b0;
    chk("dis_no_nchar_sent", 32'(n_ns), 32'd0);
    chk("dis_sel_zero", 32'(char_sel), 32'd0);
    en = 1'b1;
    wait_start("rst");
    cyc(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", 32'(char_sel), 32'd0);
    chk("async_rst_pulses", 32'({char_start, ready_tx, fct_sent, nchar_sent, tick_ack, credit_zero}), 32'd0);
    #1 rst = 1'b0;
    cyc(3);

    // Randomized traffic
    auto_done = 1'b0;
    repeat (3000) begin
      en         = ($urandom_range(0, 99) < 97);
      send_null  = ($urandom_range(0, 3) != 0);
      send_fct   = ($urandom_range(0, 2) != 0);
      send_nchar = ($urandom_range(0, 3) != 0);
      tickin     = ($urandom_range(0, 9) == 0);
      fct_owed   = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      credit     = ($urandom_range(0, 3) == 0) ? '0 : CREDIT_W'($urandom_range(1, 63));
      txwrite    = ($urandom_range(0, 1) == 1);
      char_done  = ($urandom_range(0, 2) == 0);
      cyc(1);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 check_all();
        #1 rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
